// File: rtl/aclock_pkg.sv
// rtl/aclock_pkg.sv - shared types, digit selects, digit limits and digit helpers for the time setter
package aclock_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EDIT_T,
    ST_EDIT_A,
    ST_LOAD_T,
    ST_LOAD_A
  } state_t;

  localparam logic [1:0] SEL_H1 = 2'd0;
  localparam logic [1:0] SEL_H0 = 2'd1;
  localparam logic [1:0] SEL_M1 = 2'd2;
  localparam logic [1:0] SEL_M0 = 2'd3;

  localparam logic [1:0] MAX_H1    = 2'd2;
  localparam logic [3:0] MAX_H0    = 4'd9;
  localparam logic [3:0] MAX_H0_20 = 4'd3;
  localparam logic [3:0] MAX_M1    = 4'd5;
  localparam logic [3:0] MAX_M0    = 4'd9;

  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] mx);
    return (d > mx) ? mx : d;
  endfunction

  function automatic logic [3:0] inc_digit(input logic [3:0] d, input logic [3:0] mx);
    return (d >= mx) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/aclock_time_setter_if.sv
// rtl/aclock_time_setter_if.sv - load interface between the time setter and the clock core
interface aclock_time_setter_if;
  logic [1:0] H_in1;
  logic [3:0] H_in0;
  logic [3:0] M_in1;
  logic [3:0] M_in0;
  logic       LD_time;
  logic       LD_alarm;

  modport master (output H_in1, H_in0, M_in1, M_in0, LD_time, LD_alarm);
  modport slave  (input  H_in1, H_in0, M_in1, M_in0, LD_time, LD_alarm);
endinterface

// File: rtl/aclock_btn_debounce.sv
// rtl/aclock_btn_debounce.sv - 2-FF synchronizer, stable-level debounce and one-cycle press pulse
module aclock_btn_debounce #(
  parameter int DB_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);
  localparam int CW = $clog2(DB_CYCLES + 1);

  logic          sync1, sync2, level, level_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= btn;
      sync2   <= sync1;
      level_q <= level;
      // Any bounce back to the current level restarts the stability count.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DB_CYCLES - 1)) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign press = level & ~level_q;
endmodule

// File: rtl/aclock_time_setter.sv
// rtl/aclock_time_setter.sv - button-driven HH:MM editor that loads time or alarm into the clock core
module aclock_time_setter
  import aclock_pkg::*;
#(
  parameter int DB_CYCLES  = 2,
  parameter int LD_HOLD    = 12,
  parameter int TIMEOUT    = 300,
  parameter int BLINK_HALF = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 btn_mode,
  input  logic                 btn_next,
  input  logic                 btn_inc,
  input  logic [1:0]           cur_h1,
  input  logic [3:0]           cur_h0,
  input  logic [3:0]           cur_m1,
  input  logic [3:0]           cur_m0,
  aclock_time_setter_if.master ld,
  output logic [1:0]           edit_sel,
  output logic                 edit_alm,
  output logic                 blink
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int LW = $clog2(LD_HOLD + 1);
  localparam int BW = $clog2(BLINK_HALF + 1);

  logic          p_mode, p_next, p_inc;
  logic          act_mode, act_next, act_inc, any_press;
  state_t        state;
  logic [1:0]    h1, a_h1, c_h1, n_h1;
  logic [3:0]    h0, m1, m0, a_h0, a_m1, a_m0, c_h0;
  logic          ld_time, ld_alarm;
  logic [TW-1:0] to_cnt;
  logic [LW-1:0] ld_cnt;
  logic [BW-1:0] bl_cnt;

  aclock_btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_mode (.clk(clk), .reset(reset), .btn(btn_mode), .press(p_mode));
  aclock_btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_next (.clk(clk), .reset(reset), .btn(btn_next), .press(p_next));
  aclock_btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_inc  (.clk(clk), .reset(reset), .btn(btn_inc),  .press(p_inc));

  assign act_mode  = p_mode;
  assign act_next  = p_next & ~p_mode;
  assign act_inc   = p_inc & ~p_mode & ~p_next;
  assign any_press = p_mode | p_next | p_inc;

  always_comb begin
    c_h1 = (cur_h1 > MAX_H1) ? MAX_H1 : cur_h1;
    c_h0 = clamp_digit(cur_h0, (c_h1 == MAX_H1) ? MAX_H0_20 : MAX_H0);
    n_h1 = (h1 >= MAX_H1) ? 2'd0 : h1 + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_IDLE;
      {h1, h0, m1, m0}         <= '0;
      {a_h1, a_h0, a_m1, a_m0} <= '0;
      ld_time  <= 1'b0;
      ld_alarm <= 1'b0;
      edit_sel <= SEL_H1;
      edit_alm <= 1'b0;
      blink    <= 1'b0;
      to_cnt   <= '0;
      ld_cnt   <= '0;
      bl_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          blink <= 1'b0;
          if (act_mode) begin
            state    <= ST_EDIT_T;
            h1       <= c_h1;
            h0       <= c_h0;
            m1       <= clamp_digit(cur_m1, MAX_M1);
            m0       <= clamp_digit(cur_m0, MAX_M0);
            edit_sel <= SEL_H1;
            to_cnt   <= '0;
            bl_cnt   <= '0;
            blink    <= 1'b1;
          end
        end
        ST_EDIT_T, ST_EDIT_A: begin
          if (any_press) begin
            to_cnt <= '0;
            bl_cnt <= '0;
            blink  <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
            if (bl_cnt == BW'(BLINK_HALF - 1)) begin
              bl_cnt <= '0;
              blink  <= ~blink;
            end else begin
              bl_cnt <= bl_cnt + 1'b1;
            end
          end
          if (act_mode) begin
            if (state == ST_EDIT_T) begin
              state    <= ST_EDIT_A;
              {h1, h0, m1, m0} <= {a_h1, a_h0, a_m1, a_m0};
              edit_sel <= SEL_H1;
              edit_alm <= 1'b1;
            end else begin
              state    <= ST_IDLE;
              edit_sel <= SEL_H1;
              edit_alm <= 1'b0;
              blink    <= 1'b0;
            end
          end else if (act_next) begin
            if (edit_sel == SEL_M0) begin
              state    <= (state == ST_EDIT_T) ? ST_LOAD_T : ST_LOAD_A;
              ld_time  <= (state == ST_EDIT_T);
              ld_alarm <= (state == ST_EDIT_A);
              ld_cnt   <= '0;
              blink    <= 1'b0;
              if (state == ST_EDIT_A) {a_h1, a_h0, a_m1, a_m0} <= {h1, h0, m1, m0};
            end else begin
              edit_sel <= edit_sel + 2'd1;
            end
          end else if (act_inc) begin
            case (edit_sel)
              SEL_H1: begin
                h1 <= n_h1;
                // Entering the 20s must never leave an hour of 24..29 on the digits.
                if (n_h1 == MAX_H1 && h0 > MAX_H0_20) h0 <= MAX_H0_20;
              end
              SEL_H0:  h0 <= inc_digit(h0, (h1 == MAX_H1) ? MAX_H0_20 : MAX_H0);
              SEL_M1:  m1 <= inc_digit(m1, MAX_M1);
              default: m0 <= inc_digit(m0, MAX_M0);
            endcase
          end else if (!any_press && to_cnt == TW'(TIMEOUT - 1)) begin
            state    <= ST_IDLE;
            edit_sel <= SEL_H1;
            edit_alm <= 1'b0;
            blink    <= 1'b0;
          end
        end
        ST_LOAD_T, ST_LOAD_A: begin
          blink <= 1'b0;
          if (ld_cnt == LW'(LD_HOLD - 1)) begin
            state    <= ST_IDLE;
            ld_time  <= 1'b0;
            ld_alarm <= 1'b0;
            edit_sel <= SEL_H1;
            edit_alm <= 1'b0;
          end else begin
            ld_cnt <= ld_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign ld.H_in1    = h1;
  assign ld.H_in0    = h0;
  assign ld.M_in1    = m1;
  assign ld.M_in0    = m0;
  assign ld.LD_time  = ld_time;
  assign ld.LD_alarm = ld_alarm;
endmodule

// File: tb/tb_aclock_time_setter.sv
// tb/tb_aclock_time_setter.sv - scoreboard bench for the alarm clock time setter
module tb_aclock_time_setter;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_mode = 1'b0, btn_next = 1'b0, btn_inc = 1'b0;
  logic [1:0] cur_h1 = 2'd1;
  logic [3:0] cur_h0 = 4'd3, cur_m1 = 4'd4, cur_m0 = 4'd7;
  logic [1:0] edit_sel;
  logic       edit_alm, blink;

  aclock_time_setter_if ld_if ();

  aclock_time_setter dut (
    .clk(clk), .reset(reset),
    .btn_mode(btn_mode), .btn_next(btn_next), .btn_inc(btn_inc),
    .cur_h1(cur_h1), .cur_h0(cur_h0), .cur_m1(cur_m1), .cur_m0(cur_m0),
    .ld(ld_if), .edit_sel(edit_sel), .edit_alm(edit_alm), .blink(blink)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int digits();
    return ld_if.H_in1 * 1000 + ld_if.H_in0 * 100 + ld_if.M_in1 * 10 + ld_if.M_in0;
  endfunction

  typedef struct {
    bit alarm;
    int dig;
    int width;
  } exp_t;

  exp_t q[$];
  exp_t cur_exp;
  bit   active = 1'b0;
  bit   prev_ld = 1'b0;
  int   width = 0;

  always @(negedge clk) begin
    bit now_ld;
    now_ld = ld_if.LD_time | ld_if.LD_alarm;
    if (ld_if.LD_time && ld_if.LD_alarm) check("ld_exclusive", 1, 0);
    if (now_ld && !prev_ld) begin
      if (q.size() == 0) begin
        check("unexpected_load", 1, 0);
      end else begin
        cur_exp = q.pop_front();
        active  = 1'b1;
        width   = 1;
        check("load_kind_alarm", int'(ld_if.LD_alarm), int'(cur_exp.alarm));
        check("load_digits", digits(), cur_exp.dig);
      end
    end else if (now_ld && prev_ld) begin
      width++;
    end else if (!now_ld && prev_ld && active) begin
      check("load_width", width, cur_exp.width);
      active = 1'b0;
    end
    prev_ld = now_ld;
  end

  task automatic press(input logic m, input logic n, input logic i);
    @(negedge clk);
    btn_mode = m; btn_next = n; btn_inc = i;
    repeat (6) @(negedge clk);
    btn_mode = 1'b0; btn_next = 1'b0; btn_inc = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic check_blinking(input string name);
    int   toggles;
    logic p;
    toggles = 0;
    p = blink;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (blink !== p) toggles++;
      p = blink;
    end
    check(name, int'(toggles >= 2), 1);
  endtask

  initial begin
    bit found;
    repeat (3) @(negedge clk);
    check("reset_digits", digits(), 0);
    check("reset_ld", int'({ld_if.LD_time, ld_if.LD_alarm}), 0);
    check("reset_sel_alm_blink", int'({edit_sel, edit_alm, blink}), 0);
    reset = 1'b1;

    // Enter time edit from 13:47.
    press(1, 0, 0);
    check("edit_t_digits", digits(), 1347);
    check("edit_t_sel", int'(edit_sel), 0);
    check("edit_t_alm", int'(edit_alm), 0);
    check_blinking("edit_t_blink");

    // Set 17:47 and load time.
    press(0, 1, 0);
    check("sel_after_next", int'(edit_sel), 1);
    repeat (4) press(0, 0, 1);
    check("h0_incremented", digits(), 1747);
    press(0, 1, 0);
    press(0, 1, 0);
    check("sel_m0", int'(edit_sel), 3);
    q.push_back('{alarm: 1'b0, dig: 1747, width: 12});
    press(0, 1, 0);
    check("ld_time_in_load", int'(ld_if.LD_time), 1);
    check("blink_in_load", int'(blink), 0);
    repeat (10) @(negedge clk);
    check("idle_after_load_ld", int'({ld_if.LD_time, ld_if.LD_alarm}), 0);
    check("idle_after_load_blink", int'(blink), 0);
    check("idle_holds_digits", digits(), 1747);

    // H1 wrap with H0 clamp from 19:05.
    cur_h1 = 2'd1; cur_h0 = 4'd9; cur_m1 = 4'd0; cur_m0 = 4'd5;
    press(1, 0, 0);
    check("edit_1905", digits(), 1905);
    press(0, 0, 1);
    check("h1_to_2_clamps_h0", digits(), 2305);
    press(0, 0, 1);
    check("h1_wraps_to_0", digits(), 305);

    // Alarm edit: set 06:30 and load.
    press(1, 0, 0);
    check("alarm_shadow_reset", digits(), 0);
    check("edit_alm_set", int'(edit_alm), 1);
    press(0, 1, 0);
    repeat (6) press(0, 0, 1);
    press(0, 1, 0);
    repeat (3) press(0, 0, 1);
    press(0, 1, 0);
    check("alarm_digits", digits(), 630);
    q.push_back('{alarm: 1'b1, dig: 630, width: 12});
    press(0, 1, 0);
    repeat (10) @(negedge clk);
    check("alm_cleared_after_load", int'(edit_alm), 0);
    press(1, 0, 0);
    press(1, 0, 0);
    check("alarm_shadow_kept", digits(), 630);
    check("edit_alm_again", int'(edit_alm), 1);
    press(1, 0, 0);
    check("cancel_alm", int'(edit_alm), 0);
    check("cancel_blink", int'(blink), 0);

    // MODE + INC together: only the mode change happens.
    press(1, 0, 0);
    check("edit_t_again", digits(), 1905);
    press(1, 0, 1);
    check("mode_wins_digits", digits(), 630);
    check("mode_wins_alm", int'(edit_alm), 1);
    press(1, 0, 0);

    // One-cycle glitch on MODE is not a press.
    @(negedge clk);
    btn_mode = 1'b1;
    @(negedge clk);
    btn_mode = 1'b0;
    repeat (10) @(negedge clk);
    check("glitch_blink", int'(blink), 0);
    check("glitch_digits", digits(), 630);

    // Out-of-range current time clamps on entry, then idle timeout.
    cur_h1 = 2'd3; cur_h0 = 4'd7; cur_m1 = 4'd7; cur_m0 = 4'd12;
    press(1, 0, 0);
    check("entry_clamp", digits(), 2359);
    repeat (280) @(negedge clk);
    check_blinking("still_editing_before_timeout");
    repeat (20) @(negedge clk);
    check("timeout_blink", int'(blink), 0);
    press(0, 0, 1);
    check("timeout_idle_ignores_inc", digits(), 2359);
    check("timeout_idle_blink", int'(blink), 0);

    // Reset in the middle of a time load.
    press(1, 0, 0);
    repeat (3) press(0, 1, 0);
    q.push_back('{alarm: 1'b0, dig: 2359, width: 4});
    @(negedge clk);
    btn_next = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ld_if.LD_time) begin
        found = 1'b1;
        break;
      end
    end
    check("ld_time_seen", int'(found), 1);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    btn_next = 1'b0;
    @(negedge clk);
    check("ld_time_cleared_by_reset", int'(ld_if.LD_time), 0);
    check("reset_mid_load_digits", digits(), 0);
    check("reset_mid_load_state", int'({edit_sel, edit_alm, blink}), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    check("no_load_after_reset", int'({ld_if.LD_time, ld_if.LD_alarm}), 0);
    check("scoreboard_drained", q.size(), 0);
    check("no_load_in_flight", int'(active), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
